// File: rtl/glyph_pkg.sv
// rtl/glyph_pkg.sv - shared glyph RAM geometry, address width helper and writer state type
package glyph_pkg;

    localparam int GLYPH_W         = 24;
    localparam int GLYPH_H         = 24;
    localparam int GLYPH_N         = 10;
    localparam int GLYPH_PIX       = GLYPH_W * GLYPH_H;
    localparam int RAM_DEPTH       = GLYPH_PIX * GLYPH_N;
    localparam int ADDR_W          = $clog2(RAM_DEPTH);
    localparam int BYTES_PER_GLYPH = (GLYPH_PIX + 7) / 8;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} glyph_wr_state_t;

    // Address width for an arbitrary glyph geometry; never narrower than one bit.
    function automatic int addr_width(input int w, input int h, input int n);
        return (w * h * n > 1) ? $clog2(w * h * n) : 1;
    endfunction

endpackage

// File: rtl/glyph_bit_unpacker.sv
// rtl/glyph_bit_unpacker.sv - byte to MSB-first bit shifter with bit counter
// Ports:
//   pixel_clk_in, rst_in : clock and synchronous active-high reset
//   load                 : capture byte_data, restart the bit count
//   shift                : move to the next bit
//   byte_data            : packed pixel byte, bit 7 first
//   msb                  : current pixel bit
//   last_bit             : high while the eighth bit of the byte is presented
module glyph_bit_unpacker (
    input  logic       pixel_clk_in,
    input  logic       rst_in,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] byte_data,
    output logic       msb,
    output logic       last_bit
);

    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= byte_data;
            bit_cnt <= '0;
        end else if (shift) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign msb      = shreg[7];
    assign last_bit = (bit_cnt == 3'd7);

endmodule

// File: rtl/glyph_ram_writer.sv
// rtl/glyph_ram_writer.sv - unpacks a byte stream into per-pixel writes of one glyph slot
// Ports:
//   pixel_clk_in, rst_in          : clock and synchronous active-high reset
//   start_in, glyph_in            : request to load slot glyph_in (taken only when idle)
//   byte_in, byte_valid_in        : packed pixel byte source, bit 7 first
//   byte_ready_out                : byte accepted on this cycle when valid
//   wr_en_out, wr_addr_out,
//   wr_data_out                   : single-bit RAM write port
//   busy_out, done_out, error_out : load status, completion pulse, bad-slot pulse
module glyph_ram_writer
    import glyph_pkg::*;
#(
    parameter  int WIDTH    = GLYPH_W,
    parameter  int HEIGHT   = GLYPH_H,
    parameter  int NUM_IMGS = GLYPH_N,
    localparam int ADDR_W   = addr_width(WIDTH, HEIGHT, NUM_IMGS)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [3:0]        glyph_in,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid_in,
    output logic              byte_ready_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic              wr_data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out
);

    localparam int PIX   = WIDTH * HEIGHT;
    localparam int CNT_W = (PIX > 1) ? $clog2(PIX) : 1;

    glyph_wr_state_t   state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  pix_cnt;
    logic              err_q;
    logic              bad_glyph, accept_start, last_pix;
    logic              load, shift, msb, last_bit;

    assign bad_glyph    = ({28'd0, glyph_in} >= 32'(NUM_IMGS));
    assign accept_start = (state == IDLE) && start_in && !bad_glyph;
    assign last_pix     = (pix_cnt == CNT_W'(PIX - 1));

    glyph_bit_unpacker u_unpacker (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .load         (load),
        .shift        (shift),
        .byte_data    (byte_in),
        .msb          (msb),
        .last_bit     (last_bit)
    );

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The address is kept as a running register rather than base+pix_cnt so the
    // RAM port is driven directly from a flop.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            addr    <= '0;
            pix_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && start_in && bad_glyph;
            if (accept_start) begin
                addr    <= ADDR_W'(glyph_in) * ADDR_W'(PIX);
                pix_cnt <= '0;
            end else if (state == SHIFT) begin
                addr    <= addr + 1'b1;
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        byte_ready_out = 1'b0;
        wr_en_out      = 1'b0;
        busy_out       = (state != IDLE);
        done_out       = 1'b0;
        load           = 1'b0;
        shift          = 1'b0;
        case (state)
            IDLE: begin
                if (accept_start) state_next = LOAD;
            end
            LOAD: begin
                byte_ready_out = 1'b1;
                if (byte_valid_in) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                wr_en_out = 1'b1;
                shift     = 1'b1;
                // Glyph end wins over byte end: trailing bits of a partial final byte are dropped.
                if (last_pix)      state_next = DONE;
                else if (last_bit) state_next = LOAD;
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_addr_out = addr;
    assign wr_data_out = msb & (state == SHIFT);
    assign error_out   = err_q;

endmodule
